// File: rtl/mole_spawner_pkg.sv
// mole_spawner_pkg: FSM state encodings, default game timing constants and a small helper.
package mole_spawner_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GAP   = 2'd1,
      S_SPAWN = 2'd2,
      S_UP    = 2'd3
   } state_t;

   localparam int DEF_NUM_MOLES    = 8;
   localparam int DEF_TICK_CYCLES  = 500000;
   localparam int DEF_GAP_TICKS    = 25;
   localparam int DEF_UP_MIN_TICKS = 50;
   localparam int DEF_UP_RAND_W    = 6;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mole_spawner_tick_prescaler.sv
// mole_spawner_tick_prescaler: one-cycle game tick every TICK_CYCLES clocks while enabled.
module mole_spawner_tick_prescaler
   import mole_spawner_pkg::*;
#(
   parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_enable,
   output logic o_tick
);

   localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

   logic [CW-1:0] r_cnt;
   logic          w_wrap;

   assign w_wrap = (r_cnt == CW'(TICK_CYCLES - 1));
   assign o_tick = i_enable && w_wrap;

   always_ff @(posedge i_clock) begin
      if (i_reset || !i_enable || w_wrap) r_cnt <= '0;
      else r_cnt <= r_cnt + 1'b1;
   end

endmodule

// File: rtl/mole_spawner.sv
// mole_spawner: schedules one mole at a time from the LFSR word -- gap, random hole,
// random up time, then hit or miss.
module mole_spawner
   import mole_spawner_pkg::*;
#(
   parameter int NUM_MOLES    = DEF_NUM_MOLES,
   parameter int TICK_CYCLES  = DEF_TICK_CYCLES,
   parameter int GAP_TICKS    = DEF_GAP_TICKS,
   parameter int UP_MIN_TICKS = DEF_UP_MIN_TICKS,
   parameter int UP_RAND_W    = DEF_UP_RAND_W,
   localparam int IDX_W       = $clog2(NUM_MOLES)
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_enable,
   input  logic [15:0]          i_ran_num,
   input  logic [NUM_MOLES-1:0] i_whack,
   output logic [NUM_MOLES-1:0] o_mole_up,
   output logic [IDX_W-1:0]     o_cur_mole,
   output logic                 o_spawn_pulse,
   output logic                 o_hit_pulse,
   output logic                 o_miss_pulse
);

   localparam int CW = max2($clog2(GAP_TICKS + 1), $clog2(UP_MIN_TICKS + 2**UP_RAND_W));

   state_t               r_state, w_state_nx;
   logic [CW-1:0]        r_cnt, w_cnt_nx;
   logic                 r_armed, w_armed_nx;
   logic                 w_tick, w_expire, w_hit, w_unused;
   logic [IDX_W-1:0]     w_idx, w_cur_nx;
   logic [NUM_MOLES-1:0] w_mole_up_nx;
   logic                 w_spawn_nx, w_hit_nx, w_miss_nx;

   mole_spawner_tick_prescaler #(.TICK_CYCLES(TICK_CYCLES)) u_prescaler (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_enable (i_enable),
      .o_tick   (w_tick)
   );

   assign w_unused = &{1'b0, i_ran_num};
   assign w_expire = w_tick && (r_cnt <= CW'(1));
   assign w_hit    = (r_state == S_UP) && i_whack[o_cur_mole];
   // r_armed is clear for the first spawn after reset/IDLE, so no repeat-avoidance then
   assign w_idx    = i_ran_num[IDX_W-1:0] + IDX_W'(r_armed && (i_ran_num[IDX_W-1:0] == o_cur_mole));

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_armed       <= 1'b0;
         o_mole_up     <= '0;
         o_cur_mole    <= '0;
         o_spawn_pulse <= 1'b0;
         o_hit_pulse   <= 1'b0;
         o_miss_pulse  <= 1'b0;
      end else begin
         r_state       <= w_state_nx;
         r_cnt         <= w_cnt_nx;
         r_armed       <= w_armed_nx;
         o_mole_up     <= w_mole_up_nx;
         o_cur_mole    <= w_cur_nx;
         o_spawn_pulse <= w_spawn_nx;
         o_hit_pulse   <= w_hit_nx;
         o_miss_pulse  <= w_miss_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      if (!i_enable) begin
         w_state_nx = S_IDLE;
         w_cnt_nx   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_state_nx = S_GAP;
               w_cnt_nx   = CW'(GAP_TICKS);
            end
            S_GAP: begin
               w_cnt_nx   = w_tick ? r_cnt - 1'b1 : r_cnt;
               w_state_nx = w_expire ? S_SPAWN : S_GAP;
            end
            S_SPAWN: begin
               w_state_nx = S_UP;
               w_cnt_nx   = CW'(UP_MIN_TICKS) + CW'(i_ran_num[15 -: UP_RAND_W]);
            end
            default: begin
               w_state_nx = (w_hit || w_expire) ? S_GAP : S_UP;
               w_cnt_nx   = (w_hit || w_expire) ? CW'(GAP_TICKS) : (w_tick ? r_cnt - 1'b1 : r_cnt);
            end
         endcase
      end
   end

   always_comb begin
      w_mole_up_nx = o_mole_up;
      w_cur_nx     = o_cur_mole;
      w_armed_nx   = r_armed;
      w_spawn_nx   = 1'b0;
      w_hit_nx     = 1'b0;
      w_miss_nx    = 1'b0;
      if (!i_enable) begin
         w_mole_up_nx = '0;
         w_armed_nx   = 1'b0;
      end else if (r_state == S_SPAWN) begin
         w_mole_up_nx = {{(NUM_MOLES-1){1'b0}}, 1'b1} << w_idx;
         w_cur_nx     = w_idx;
         w_armed_nx   = 1'b1;
         w_spawn_nx   = 1'b1;
      end else if (r_state == S_UP && (w_hit || w_expire)) begin
         w_mole_up_nx = '0;
         w_hit_nx     = w_hit;
         w_miss_nx    = !w_hit;
      end
   end

endmodule

// File: tb/tb_mole_spawner.sv
// tb_mole_spawner: directed checks of spawn timing, index selection, hit/miss and abort paths.
module tb_mole_spawner;

   logic        clk = 1'b0;
   logic        rst, en;
   logic [15:0] ran;
   logic [7:0]  whack;
   logic [7:0]  o_mole_up;
   logic [2:0]  o_cur_mole;
   logic        o_spawn, o_hit, o_miss;
   int          checks = 0;
   int          errors = 0;
   int          n;

   mole_spawner #(
      .NUM_MOLES(8), .TICK_CYCLES(1), .GAP_TICKS(2), .UP_MIN_TICKS(4), .UP_RAND_W(2)
   ) dut (
      .i_clock       (clk),
      .i_reset       (rst),
      .i_enable      (en),
      .i_ran_num     (ran),
      .i_whack       (whack),
      .o_mole_up     (o_mole_up),
      .o_cur_mole    (o_cur_mole),
      .o_spawn_pulse (o_spawn),
      .o_hit_pulse   (o_hit),
      .o_miss_pulse  (o_miss)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_spawn(output int cnt);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (!o_spawn && cnt < 50);
   endtask

   task automatic run_up(output int cnt);
      cnt = 0;
      while (o_mole_up != 0 && cnt < 50) begin
         cnt++;
         step();
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; whack = 8'hFF; ran = 16'h0000;
      repeat (3) begin
         step();
         check("reset_outs", 32'({o_mole_up, o_cur_mole, o_spawn, o_hit, o_miss}), 0);
      end
      rst = 1'b0; whack = 8'h00; ran = 16'h0005;
      wait_spawn(n);
      check("s1_latency", n, 4);
      check("s1_mole_up", 32'(o_mole_up), 32'h20);
      check("s1_cur", 32'(o_cur_mole), 5);
      ran = 16'hC005;
      run_up(n);
      check("s1_up_ticks", n, 4);
      check("s1_miss", 32'({o_hit, o_miss}), 2'b01);
      step();
      check("s1_miss_once", 32'(o_miss), 0);
      wait_spawn(n);
      check("s2_gap", n, 2);
      check("s2_no_repeat_up", 32'(o_mole_up), 32'h40);
      check("s2_cur", 32'(o_cur_mole), 6);
      ran = 16'h0005;
      run_up(n);
      check("s2_up_ticks", n, 7);
      check("s2_miss", 32'({o_hit, o_miss}), 2'b01);
      wait_spawn(n);
      check("s3_gap", n, 3);
      check("s3_mole_up", 32'(o_mole_up), 32'h20);
      ran = 16'h0004;
      step();
      whack = 8'h20;
      step();
      whack = 8'h00;
      check("s3_hit", 32'({o_hit, o_miss}), 2'b10);
      check("s3_down", 32'(o_mole_up), 0);
      step();
      check("s3_no_miss", 32'({o_hit, o_miss}), 0);
      whack = 8'hEF;
      wait_spawn(n);
      check("s4_gap", n, 2);
      check("s4_mole_up", 32'(o_mole_up), 32'h10);
      ran = 16'h0005;
      run_up(n);
      check("s4_wrong_whack_up", n, 4);
      check("s4_miss", 32'({o_hit, o_miss}), 2'b01);
      whack = 8'h00;
      wait_spawn(n);
      check("s5_gap", n, 3);
      check("s5_mole_up", 32'(o_mole_up), 32'h20);
      ran = 16'h0002;
      repeat (3) step();
      whack = 8'h20;
      step();
      whack = 8'h00;
      check("s5_hit_at_expiry", 32'({o_hit, o_miss}), 2'b10);
      check("s5_down", 32'(o_mole_up), 0);
      step();
      check("s5_no_miss", 32'({o_hit, o_miss}), 0);
      wait_spawn(n);
      check("s6_gap", n, 2);
      check("s6_mole_up", 32'(o_mole_up), 32'h04);
      step();
      en = 1'b0;
      step();
      check("dis_down", 32'({o_mole_up, o_spawn, o_hit, o_miss}), 0);
      repeat (3) step();
      check("dis_idle", 32'({o_mole_up, o_spawn, o_hit, o_miss}), 0);
      en = 1'b1;
      wait_spawn(n);
      check("reen_latency", n, 4);
      check("reen_first_idx", 32'(o_cur_mole), 2);
      check("reen_mole_up", 32'(o_mole_up), 32'h04);
      ran = 16'h0000;
      step();
      rst = 1'b1;
      step();
      check("rst_mid_up", 32'({o_mole_up, o_cur_mole, o_spawn, o_hit, o_miss}), 0);
      rst = 1'b0;
      wait_spawn(n);
      check("rst_latency", n, 4);
      check("rst_first_idx", 32'(o_cur_mole), 0);
      check("rst_mole_up", 32'(o_mole_up), 32'h01);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
